// File: rtl/clock_div_pkg.sv
// clock_div_pkg
//   Shared types and constants for the divided-clock controller.
//   clkdiv_state_t : controller state encoding (IDLE, RUN, STOPPING)
//   CLKDIV_MIN_DIV : smallest divisor that produces a valid period
//   CLKDIV_CNT_W   : default divisor / period counter width
package clock_div_pkg;

    localparam int CLKDIV_CNT_W   = 28;
    localparam int CLKDIV_MIN_DIV = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } clkdiv_state_t;

endpackage

// File: rtl/clock_div_ctrl_if.sv
// clock_div_ctrl_if
//   Divisor configuration handshake between a host/CSR block and the
//   divided-clock controller.
//   cfg_valid  master->slave  new divisor offered
//   cfg_div    master->slave  offered divisor (CNT_W bits)
//   cfg_ready  slave->master  controller can take a divisor
//   cfg_err    slave->master  one-cycle pulse: last accepted divisor was illegal
interface clock_div_ctrl_if #(
    parameter int CNT_W = 28
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clock_div_core.sv
// clock_div_core
//   Period counter plus registered clock_out / tick decode.
//   clock_in   system clock (rising edge)
//   reset_n    asynchronous active-low reset
//   en         counting enabled (controller not idle)
//   clr        force the counter to 0
//   div        active divisor, always >= 2
//   pe         combinational period end (cnt == div-1 while enabled)
//   clock_out  registered: high while cnt < div>>1, low when disabled
//   tick       registered: one pulse per completed period
module clock_div_core #(
    parameter int CNT_W = 28
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] div,
    output logic             pe,
    output logic             clock_out,
    output logic             tick
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_m1;
    logic [CNT_W-1:0] half;

    // div never drops below 2, so div-1 cannot underflow
    assign div_m1 = div - CNT_W'(1);
    assign half   = div >> 1;
    assign pe     = en && (cnt == div_m1);

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            clock_out <= 1'b0;
            tick      <= 1'b0;
        end else begin
            if (clr) begin
                cnt <= '0;
            end else if (en) begin
                cnt <= pe ? '0 : cnt + CNT_W'(1);
            end
            // decode of the pre-edge count: outputs trail cnt by one cycle
            clock_out <= en && (cnt < half);
            tick      <= pe;
        end
    end

endmodule

// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl
//   Run-time controller for a programmable divided clock. Starts/stops
//   cleanly on period boundaries and applies divisor changes only at a
//   period end, so no runt pulses reach the slow domain.
//   clock_in    system clock (rising edge)
//   reset_n     asynchronous active-low reset
//   cfg         divisor handshake (clock_div_ctrl_if.slave)
//   start       request to run (level or pulse)
//   stop        request to stop at the end of the current period
//   clock_out   divided clock
//   tick        one-cycle pulse per completed period
//   busy        controller not idle
//   period_cnt  (only with CLOCK_DIV_CTRL_PERIOD_CNT_EN) 16-bit wrapping
//               count of completed periods
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   IDLE     | counter held at 0, clock_out low, divisor written directly
//   RUN      | counting; stop request moves to STOPPING
//   STOPPING | counting; returns to IDLE at period end unless restarted
module clock_div_ctrl
    import clock_div_pkg::*;
#(
    parameter int CNT_W       = CLKDIV_CNT_W,
    parameter int DEFAULT_DIV = 16
) (
    input  logic                   clock_in,
    input  logic                   reset_n,
    clock_div_ctrl_if.slave        cfg,
    input  logic                   start,
    input  logic                   stop,
    output logic                   clock_out,
    output logic                   tick,
    output logic                   busy
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
    ,
    output logic [15:0]            period_cnt
`endif
);

    localparam logic [1:0] ST_IDLE     = IDLE;
    localparam logic [1:0] ST_RUN      = RUN;
    localparam logic [1:0] ST_STOPPING = STOPPING;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_q;
    logic             pend_v;
    logic             cfg_err_q;
    logic             xfer;
    logic             div_legal;
    logic             pe;
    logic             run_en;

    assign cfg.cfg_ready = !pend_v;
    assign cfg.cfg_err   = cfg_err_q;
    assign xfer          = cfg.cfg_valid && !pend_v;
    assign div_legal     = cfg.cfg_div >= CNT_W'(CLKDIV_MIN_DIV);
    assign run_en        = (state != ST_IDLE);
    assign busy          = run_en;

    clock_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .en        (run_en),
        .clr       (!run_en),
        .div       (div_q),
        .pe        (pe),
        .clock_out (clock_out),
        .tick      (tick)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                // stop wins over a simultaneous start
                if (start && !stop) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stop) state_nxt = ST_STOPPING;
            end
            ST_STOPPING: begin
                // a restart cancels the stop without touching the count
                if (start && !stop) state_nxt = ST_RUN;
                else if (pe)        state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            div_q     <= CNT_W'(DEFAULT_DIV);
            pend_q    <= '0;
            pend_v    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cfg_err_q <= xfer && !div_legal;

            // a value accepted in the same cycle as pe is not yet pending,
            // so it waits for the following period end
            if (pe && pend_v) begin
                div_q  <= pend_q;
                pend_v <= 1'b0;
            end

            // xfer requires !pend_v, so this never collides with the apply above
            if (xfer && div_legal) begin
                if (state == ST_IDLE) begin
                    div_q <= cfg.cfg_div;
                end else begin
                    pend_q <= cfg.cfg_div;
                    pend_v <= 1'b1;
                end
            end
        end
    end

`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
    // pe is the same event that raises tick on this edge
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
        end else if (pe) begin
            period_cnt <= period_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clock_div_ctrl.sv
module tb_clock_div_ctrl;

    localparam int CNT_W = 28;

    logic clock_in = 1'b0;
    logic reset_n  = 1'b0;
    logic start    = 1'b0;
    logic stop     = 1'b0;
    logic clock_out;
    logic tick;
    logic busy;
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    clock_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    clock_div_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (16)
    ) dut (
        .clock_in  (clock_in),
        .reset_n   (reset_n),
        .cfg       (cfg_if.slave),
        .start     (start),
        .stop      (stop),
        .clock_out (clock_out),
        .tick      (tick),
        .busy      (busy)
`ifdef CLOCK_DIV_CTRL_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        bit          prog;
        int unsigned div;
        int unsigned hi;
        int unsigned lo;
    } vec_t;

    typedef struct {
        string       name;
        int unsigned hi;
        int unsigned lo;
        int unsigned per;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock_in);
        #1;
    endtask

    task automatic cfg_send(input int unsigned d);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div   = CNT_W'(d);
        cyc();
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_tick(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (tick) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            if (!busy) break;
            cyc();
        end
        chk(name, busy, 0);
    endtask

    // Measures one period starting at a tick sample; optionally drives stop
    // for one cycle after sample stop_at of that period.
    task automatic check_period(input bit wait_first, input int stop_at);
        exp_t e;
        bit ok;
        int unsigned hi, lo, per;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 1, 0);
            return;
        end
        e  = sb.pop_front();
        ok = 1'b1;
        hi = 0; lo = 0; per = 0;
        if (wait_first) wait_tick(ok);
        if (ok) begin
            ok = 1'b0;
            for (int j = 1; j <= 400; j++) begin
                cyc();
                if (clock_out) hi++;
                else           lo++;
                if (tick) begin
                    per = j;
                    ok  = 1'b1;
                    stop = 1'b0;
                    break;
                end
                stop = (j == stop_at);
            end
            stop = 1'b0;
        end
        chk({e.name, "_done"}, ok, 1);
        chk({e.name, "_hi"},   hi, e.hi);
        chk({e.name, "_lo"},   lo, e.lo);
        chk({e.name, "_per"},  per, e.per);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        bit ready_seen;
        int quiet;

        vecs[0] = '{prog: 1'b0, div: 16, hi: 8, lo: 8};
        vecs[1] = '{prog: 1'b1, div: 6,  hi: 3, lo: 3};
        vecs[2] = '{prog: 1'b1, div: 5,  hi: 2, lo: 3};
        vecs[3] = '{prog: 1'b1, div: 7,  hi: 3, lo: 4};
        vecs[4] = '{prog: 1'b1, div: 2,  hi: 1, lo: 1};
        vecs[5] = '{prog: 1'b1, div: 3,  hi: 1, lo: 2};
        vecs[6] = '{prog: 1'b1, div: 16, hi: 8, lo: 8};

        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;

        repeat (3) @(posedge clock_in);
        #2 reset_n = 1'b1;
        cyc();
        chk("rst_clock_out", clock_out, 0);
        chk("rst_tick",      tick, 0);
        chk("rst_cfg_err",   cfg_if.cfg_err, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_cfg_ready", cfg_if.cfg_ready, 1);

        // start latency: busy right after the sampling edge, clock_out one later
        pulse_start();
        chk("lat_busy", busy, 1);
        chk("lat_clock_out_first", clock_out, 0);
        cyc();
        chk("lat_clock_out_second", clock_out, 1);
        stop = 1'b1; cyc(); stop = 1'b0;
        wait_idle("lat_stop_idle");

        foreach (vecs[i]) begin
            if (vecs[i].prog) begin
                chk($sformatf("vec%0d_ready", i), cfg_if.cfg_ready, 1);
                cfg_send(vecs[i].div);
            end
            sb.push_back('{name: $sformatf("vec%0d_div%0d", i, vecs[i].div),
                           hi: vecs[i].hi, lo: vecs[i].lo, per: vecs[i].div});
            pulse_start();
            check_period(1'b1, -1);
            stop = 1'b1; cyc(); stop = 1'b0;
            wait_idle($sformatf("vec%0d_idle", i));
        end

        // divisor change mid-period while running at 16
        pulse_start();
        wait_tick(ok);
        chk("chg_first_tick", ok, 1);
        repeat (4) cyc();
        chk("chg_ready_before", cfg_if.cfg_ready, 1);
        cfg_send(6);
        chk("chg_ready_pending", cfg_if.cfg_ready, 0);
        sb.push_back('{name: "chg_div6", hi: 3, lo: 3, per: 6});
        n = 5;
        ready_seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n++;
            if (tick) break;
            if (cfg_if.cfg_ready) ready_seen = 1'b1;
        end
        chk("chg_old_period", n, 16);
        chk("chg_ready_held_low", ready_seen, 0);
        chk("chg_ready_after_pe", cfg_if.cfg_ready, 1);
        check_period(1'b0, -1);

        // illegal divisor: handshake completes, error pulse, period unchanged
        cfg_send(1);
        chk("ill_err_pulse", cfg_if.cfg_err, 1);
        chk("ill_ready", cfg_if.cfg_ready, 1);
        cyc();
        chk("ill_err_clear", cfg_if.cfg_err, 0);
        sb.push_back('{name: "ill_div6", hi: 3, lo: 3, per: 6});
        check_period(1'b1, -1);

        // restart during STOPPING: no gap, no stop
        stop = 1'b1; cyc(); stop = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        n = 2;
        for (int i = 0; i < 100; i++) begin
            cyc();
            n++;
            if (tick) break;
        end
        chk("resume_period", n, 6);
        chk("resume_busy", busy, 1);
        sb.push_back('{name: "resume_next", hi: 3, lo: 3, per: 6});
        check_period(1'b0, -1);
        stop = 1'b1; cyc(); stop = 1'b0;
        wait_idle("resume_stop_idle");

        // stop at cnt=1 with div 5: final period completes in full
        cfg_send(5);
        pulse_start();
        sb.push_back('{name: "stop5", hi: 2, lo: 3, per: 5});
        check_period(1'b1, 1);
        chk("stop5_idle_at_tick", busy, 0);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (clock_out || tick) quiet++;
        end
        chk("stop5_quiet", quiet, 0);

        // start and stop together in IDLE: stop wins
        start = 1'b1; stop = 1'b1; cyc(); start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        repeat (3) cyc();
        chk("startstop_busy_later", busy, 0);
        chk("startstop_clock_out", clock_out, 0);

        // reset mid-period with a pending divisor (div 5 active)
        pulse_start();
        wait_tick(ok);
        chk("rstmid_tick", ok, 1);
        cfg_send(9);
        chk("rstmid_pending", cfg_if.cfg_ready, 0);
        chk("rstmid_clock_high", clock_out, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_clock_out", clock_out, 0);
        chk("rstmid_tick_out", tick, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ready", cfg_if.cfg_ready, 1);
        chk("rstmid_err", cfg_if.cfg_err, 0);
        @(negedge clock_in);
        reset_n = 1'b1;
        cyc();
        sb.push_back('{name: "rstmid_div16", hi: 8, lo: 8, per: 16});
        pulse_start();
        check_period(1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
